// File: rtl/weight_index_sequencer.sv
// weight_index_sequencer: walks the flattened (col, channel, filter) stream in
// bursts and replays every burst across all (row, channel-set, filter-set)
// combinations, presenting one index tuple per valid/ready transfer.
// State updates on the falling clock edge; reset is asynchronous, active-high.
// Optional feature macro: WIS_ABORT_EN adds an 'abort' input that cancels a job.
module weight_index_sequencer #(
    parameter int R_WIDTH     = 4,
    parameter int S_WIDTH     = 6,
    parameter int p_WIDTH     = 5,
    parameter int q_WIDTH     = 3,
    parameter int r_WIDTH     = 2,
    parameter int t_WIDTH     = 3,
    parameter int BURST_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [R_WIDTH-1:0]         R,
    input  logic [S_WIDTH-1:0]         S,
    input  logic [p_WIDTH-1:0]         p,
    input  logic [q_WIDTH-1:0]         q,
    input  logic [r_WIDTH-1:0]         r,
    input  logic [t_WIDTH-1:0]         t,
    input  logic [BURST_WIDTH-1:0]     burst_len,
`ifdef WIS_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       ready,
    output logic                       valid,
    output logic [p_WIDTH+t_WIDTH-1:0] filter_index,
    output logic [q_WIDTH+r_WIDTH-1:0] channel_index,
    output logic [R_WIDTH-1:0]         row_index,
    output logic [S_WIDTH-1:0]         col_index,
    output logic                       burst_last,
    output logic                       job_last,
    output logic                       busy,
    output logic                       done
);

    localparam int FW = p_WIDTH + t_WIDTH;
    localparam int CW = q_WIDTH + r_WIDTH;

    typedef enum logic [1:0] {IDLE, EMIT, ADVANCE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [R_WIDTH-1:0]     row_lat_q, row_lat_d, row_cnt_q, row_cnt_d;
    logic [S_WIDTH-1:0]     col_lat_q, col_lat_d, col_cnt_q, col_cnt_d, col_save_q, col_save_d;
    logic [p_WIDTH-1:0]     fil_lat_q, fil_lat_d, fil_cnt_q, fil_cnt_d, fil_save_q, fil_save_d;
    logic [q_WIDTH-1:0]     chn_lat_q, chn_lat_d, chn_cnt_q, chn_cnt_d, chn_save_q, chn_save_d;
    logic [r_WIDTH-1:0]     cset_lat_q, cset_lat_d, cset_cnt_q, cset_cnt_d;
    logic [t_WIDTH-1:0]     fset_lat_q, fset_lat_d, fset_cnt_q, fset_cnt_d;
    logic [BURST_WIDTH-1:0] burst_lat_q, burst_lat_d, beat_cnt_q, beat_cnt_d;
    logic                   seen_end_q, seen_end_d;

    logic fil_max, chn_max, col_max, fset_max, cset_max, row_max;
    logic stream_end, replay_end, pass_end, zero_cfg;

    assign fil_max    = (fil_cnt_q == fil_lat_q - 1'b1);
    assign chn_max    = (chn_cnt_q == chn_lat_q - 1'b1);
    assign col_max    = (col_cnt_q == col_lat_q - 1'b1);
    assign fset_max   = (fset_cnt_q == fset_lat_q - 1'b1);
    assign cset_max   = (cset_cnt_q == cset_lat_q - 1'b1);
    assign row_max    = (row_cnt_q == row_lat_q - 1'b1);
    assign stream_end = fil_max && chn_max && col_max;
    assign replay_end = fset_max && cset_max && row_max;
    assign pass_end   = (beat_cnt_q == burst_lat_q - 1'b1);
    assign zero_cfg   = (R == '0) || (S == '0) || (p == '0) || (q == '0) ||
                        (r == '0) || (t == '0) || (burst_len == '0);

    assign valid         = (state_q == EMIT);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign burst_last    = valid && (pass_end || stream_end);
    assign job_last      = valid && stream_end && replay_end;
    assign filter_index  = FW'(fil_cnt_q) + FW'(fset_cnt_q) * FW'(fil_lat_q);
    assign channel_index = CW'(chn_cnt_q) + CW'(cset_cnt_q) * CW'(chn_lat_q);
    assign row_index     = row_cnt_q;
    assign col_index     = col_cnt_q;

    // Next-state logic: job launch, stream stepping per transfer, replay/burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        row_lat_d   = row_lat_q;
        col_lat_d   = col_lat_q;
        fil_lat_d   = fil_lat_q;
        chn_lat_d   = chn_lat_q;
        cset_lat_d  = cset_lat_q;
        fset_lat_d  = fset_lat_q;
        burst_lat_d = burst_lat_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        fil_cnt_d   = fil_cnt_q;
        chn_cnt_d   = chn_cnt_q;
        cset_cnt_d  = cset_cnt_q;
        fset_cnt_d  = fset_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        col_save_d  = col_save_q;
        fil_save_d  = fil_save_q;
        chn_save_d  = chn_save_q;
        seen_end_d  = seen_end_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_lat_d   = R;
                    col_lat_d   = S;
                    fil_lat_d   = p;
                    chn_lat_d   = q;
                    cset_lat_d  = r;
                    fset_lat_d  = t;
                    burst_lat_d = burst_len;
                    row_cnt_d   = '0;
                    col_cnt_d   = '0;
                    fil_cnt_d   = '0;
                    chn_cnt_d   = '0;
                    cset_cnt_d  = '0;
                    fset_cnt_d  = '0;
                    beat_cnt_d  = '0;
                    col_save_d  = '0;
                    fil_save_d  = '0;
                    chn_save_d  = '0;
                    seen_end_d  = 1'b0;
                    state_d     = zero_cfg ? DONE : EMIT;
                end
            end
            EMIT: begin
                if (ready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    seen_end_d = stream_end;
                    if (!fil_max) begin
                        fil_cnt_d = fil_cnt_q + 1'b1;
                    end else begin
                        fil_cnt_d = '0;
                        if (!chn_max) begin
                            chn_cnt_d = chn_cnt_q + 1'b1;
                        end else begin
                            chn_cnt_d = '0;
                            col_cnt_d = col_max ? '0 : col_cnt_q + 1'b1;
                        end
                    end
                    if (pass_end || stream_end) begin
                        state_d = ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                beat_cnt_d = '0;
                if (!fset_max) begin
                    fset_cnt_d = fset_cnt_q + 1'b1;
                end else begin
                    fset_cnt_d = '0;
                    if (!cset_max) begin
                        cset_cnt_d = cset_cnt_q + 1'b1;
                    end else begin
                        cset_cnt_d = '0;
                        row_cnt_d  = row_max ? '0 : row_cnt_q + 1'b1;
                    end
                end
                if (!replay_end) begin
                    col_cnt_d  = col_save_q;
                    fil_cnt_d  = fil_save_q;
                    chn_cnt_d  = chn_save_q;
                    seen_end_d = 1'b0;
                    state_d    = EMIT;
                end else if (!seen_end_q) begin
                    col_save_d = col_cnt_q;
                    fil_save_d = fil_cnt_q;
                    chn_save_d = chn_cnt_q;
                    state_d    = EMIT;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef WIS_ABORT_EN
        if (abort && (state_q == EMIT || state_q == ADVANCE)) begin
            state_d    = IDLE;
            row_cnt_d  = '0;
            col_cnt_d  = '0;
            fil_cnt_d  = '0;
            chn_cnt_d  = '0;
            cset_cnt_d = '0;
            fset_cnt_d = '0;
            beat_cnt_d = '0;
            col_save_d = '0;
            fil_save_d = '0;
            chn_save_d = '0;
            seen_end_d = 1'b0;
        end
`endif
    end

    // Falling-edge state register with asynchronous clear of all state and config.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_lat_q   <= '0;
            col_lat_q   <= '0;
            fil_lat_q   <= '0;
            chn_lat_q   <= '0;
            cset_lat_q  <= '0;
            fset_lat_q  <= '0;
            burst_lat_q <= '0;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            fil_cnt_q   <= '0;
            chn_cnt_q   <= '0;
            cset_cnt_q  <= '0;
            fset_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            col_save_q  <= '0;
            fil_save_q  <= '0;
            chn_save_q  <= '0;
            seen_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_lat_q   <= row_lat_d;
            col_lat_q   <= col_lat_d;
            fil_lat_q   <= fil_lat_d;
            chn_lat_q   <= chn_lat_d;
            cset_lat_q  <= cset_lat_d;
            fset_lat_q  <= fset_lat_d;
            burst_lat_q <= burst_lat_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            fil_cnt_q   <= fil_cnt_d;
            chn_cnt_q   <= chn_cnt_d;
            cset_cnt_q  <= cset_cnt_d;
            fset_cnt_q  <= fset_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            col_save_q  <= col_save_d;
            fil_save_q  <= fil_save_d;
            chn_save_q  <= chn_save_d;
            seen_end_q  <= seen_end_d;
        end
    end

endmodule
